// File: rtl/smm0_tile_io.sv
// smm0_tile_io: operand collector and result serialiser around the SMM0
// 2x2 Strassen multiply controller. Eight operand beats (A00..A11 then
// B00..B11) are gathered, a one-cycle load pulse starts the controller,
// the C tile is captured on write_out and drained as four output beats.
module smm0_tile_io #(
    parameter int DW = 8,
    parameter int CW = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                load,
    input  logic                write_out,
    input  logic [4*CW-1:0]     c_in,
    output logic [4*DW-1:0]     a_out,
    output logic [4*DW-1:0]     b_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_data,
    output logic                out_last,
    output logic                busy
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_KICK  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [2:0]    r_cnt;
    logic [1:0]    r_idx;
    logic [DW-1:0] r_a [4];
    logic [DW-1:0] r_b [4];
    logic [CW-1:0] r_c [4];
    logic          r_load;
    logic          r_out_valid;
    logic [CW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_busy;

    logic w_accept;
    logic w_handshake;
    logic w_capture;

    // Combinational ready is gated by reset so nothing is accepted while held.
    assign in_ready    = (r_state == S_FILL) && rst;
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = r_out_valid && out_ready;
    assign w_capture   = (r_state == S_WAIT) && write_out;

    // Next-state selection for the fill/kick/wait/drain sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (w_accept && (r_cnt == 3'd7)) w_state_next = S_KICK;
            S_KICK:  w_state_next = S_WAIT;
            S_WAIT:  if (write_out) w_state_next = S_DRAIN;
            S_DRAIN: if (w_handshake && (r_idx == 2'd3)) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // State register and operand beat counter (3 bits wrap after B11).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_cnt <= r_cnt + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elem
            // Operand element registers; each written only by its own beat.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a[gi] <= '0;
                    r_b[gi] <= '0;
                end else if (w_accept) begin
                    if (r_cnt == 3'(gi))     r_a[gi] <= in_data;
                    if (r_cnt == 3'(gi + 4)) r_b[gi] <= in_data;
                end
            end

            // Result element capture, only while waiting for the controller.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_c[gi] <= '0;
                else if (w_capture) r_c[gi] <= c_in[gi*CW +: CW];
            end

            assign a_out[gi*DW +: DW] = r_a[gi];
            assign b_out[gi*DW +: DW] = r_b[gi];
        end
    endgenerate

    // Registered control outputs derived from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_load      <= (w_state_next == S_KICK);
            r_busy      <= (w_state_next != S_FILL);
            r_out_valid <= (w_state_next == S_DRAIN);
        end
    end

    // Output beat register: C00 is presented straight from c_in on capture,
    // later beats come from the captured tile as the index advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= 2'd0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_capture) begin
            r_idx      <= 2'd0;
            r_out_data <= c_in[CW-1:0];
            r_out_last <= 1'b0;
        end else if (w_handshake) begin
            r_idx      <= r_idx + 2'd1;
            r_out_last <= (r_idx == 2'd2);
            if (r_idx != 2'd3) r_out_data <= r_c[r_idx + 2'd1];
        end
    end

    assign load      = r_load;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_smm0_tile_io.sv
// Directed bench for smm0_tile_io: one task per scenario, each with its own
// inline comparisons against hand-computed values.
module tb_smm0_tile_io;

    localparam int DW = 8;
    localparam int CW = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              load;
    logic              write_out;
    logic [4*CW-1:0]   c_in;
    logic [4*DW-1:0]   a_out;
    logic [4*DW-1:0]   b_out;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_data;
    logic              out_last;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Tile 1: A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50]
    localparam logic [63:0]     T1_OPS = 64'h0807060504030201;
    localparam logic [4*CW-1:0] T1_C   = {18'd50, 18'd43, 18'd22, 18'd19};
    // Tile 2: A=[9,10;11,12], B=[13,14;15,16] -> C=[267,286;323,346]
    localparam logic [63:0]     T2_OPS = 64'h100F0E0D0C0B0A09;
    localparam logic [4*CW-1:0] T2_C   = {18'd346, 18'd323, 18'd286, 18'd267};
    // Tile 3: distinct bytes, wide results exercising the top result bits
    localparam logic [63:0]     T3_OPS = 64'hF1E2D3C4B5A69788;
    localparam logic [4*CW-1:0] T3_C   = {18'h3FFFF, 18'h20001, 18'h15555, 18'h0AAAA};
    localparam logic [4*CW-1:0] JUNK_C = {18'h12345, 18'h2ABCD, 18'h3F00F, 18'h01111};

    smm0_tile_io #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .load      (load),
        .write_out (write_out),
        .c_in      (c_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream eight operand beats following a valid pattern, then check the
    // load pulse and held operands.
    task automatic fill_tile(input string name, input logic [63:0] vals,
                             input logic [15:0] pat, input int npat,
                             input int exp_cyc, input logic hold_valid);
        int   idx;
        int   cyc;
        logic v;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            v = (cyc < npat) ? pat[cyc] : 1'b1;
            in_valid = v;
            in_data  = vals[idx*8 +: 8];
            total++;
            if (in_ready !== 1'b1 || load !== 1'b0) begin
                bad++;
                $display("FAIL %s fill cyc%0d: in_ready=%b load=%b required 1/0", name, cyc, in_ready, load);
            end
            tick();
            if (v) idx++;
            cyc++;
        end
        in_valid = hold_valid;
        total++;
        if (cyc !== exp_cyc) begin
            bad++;
            $display("FAIL %s fill_cycles: got %0d required %0d", name, cyc, exp_cyc);
        end
        total++;
        if (load !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s kick: load=%b in_ready=%b busy=%b required 1/0/1", name, load, in_ready, busy);
        end
        total++;
        if (a_out !== vals[31:0] || b_out !== vals[63:32]) begin
            bad++;
            $display("FAIL %s operands: a_out=%h b_out=%h required %h %h", name, a_out, b_out, vals[31:0], vals[63:32]);
        end
        tick();
        total++;
        if (load !== 1'b0) begin
            bad++;
            $display("FAIL %s load_width: load=%b required 0", name, load);
        end
    endtask

    // Controller model: write_out with C exactly 4 cycles after the load cycle.
    task automatic ctrl(input string name, input logic [4*CW-1:0] c);
        repeat (3) begin
            total++;
            if (in_ready !== 1'b0 || load !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s wait: in_ready=%b load=%b out_valid=%b busy=%b required 0/0/0/1", name, in_ready, load, out_valid, busy);
            end
            tick();
        end
        write_out = 1'b1;
        c_in      = c;
        tick();
        write_out = 1'b0;
        c_in      = JUNK_C;
    endtask

    // Drain four result beats under an out_ready pattern; optionally pulse
    // write_out with junk data on cycle wo_cyc.
    task automatic drain(input string name, input logic [4*CW-1:0] c,
                         input logic [15:0] rpat, input int npat,
                         input int wo_cyc, input logic [31:0] a_exp);
        int   k;
        int   i;
        logic r;
        k = 0;
        i = 0;
        while (k < 4 && i < 40) begin
            r = (i < npat) ? rpat[i] : 1'b1;
            out_ready = r;
            if (i == wo_cyc) begin
                write_out = 1'b1;
                c_in      = JUNK_C;
            end
            total++;
            if (out_valid !== 1'b1 || out_data !== c[k*CW +: CW] ||
                out_last !== ((k == 3) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL %s beat%0d cyc%0d: valid=%b data=%0d last=%b required 1/%0d/%b", name, k, i, out_valid, out_data, out_last, c[k*CW +: CW], (k == 3));
            end
            total++;
            if (in_ready !== 1'b0 || a_out !== a_exp) begin
                bad++;
                $display("FAIL %s drain_hold cyc%0d: in_ready=%b a_out=%h required 0/%h", name, i, in_ready, a_out, a_exp);
            end
            tick();
            write_out = 1'b0;
            if (r) k++;
            i++;
        end
        total++;
        if (k !== 4) begin
            bad++;
            $display("FAIL %s drain_timeout: handshakes=%0d required 4", name, k);
        end
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s drain_end: valid=%b last=%b in_ready=%b busy=%b required 0/0/1/0", name, out_valid, out_last, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (in_ready !== 1'b0 || load !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || a_out !== '0 || b_out !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b load=%b ov=%b ol=%b od=%0d a=%h b=%h busy=%b required all 0", in_ready, load, out_valid, out_last, out_data, a_out, b_out, busy);
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        fill_tile("basic", T1_OPS, 16'hFFFF, 16, 8, 1'b0);
        ctrl("basic", T1_C);
        drain("basic", T1_C, 16'hFFFF, 16, -1, T1_OPS[31:0]);
        $display("test_basic done");
    endtask

    task automatic test_stall();
        fill_tile("stall", T1_OPS, 16'hFFFF, 16, 8, 1'b0);
        ctrl("stall", T1_C);
        drain("stall", T1_C, 16'h0069, 7, -1, T1_OPS[31:0]);
        $display("test_stall done");
    endtask

    task automatic test_bubbles();
        fill_tile("bubbles", T2_OPS, 16'h07CD, 11, 11, 1'b0);
        ctrl("bubbles", T2_C);
        drain("bubbles", T2_C, 16'hFFFF, 16, -1, T2_OPS[31:0]);
        $display("test_bubbles done");
    endtask

    task automatic test_ignore_writeout();
        write_out = 1'b1;
        c_in      = JUNK_C;
        tick();
        write_out = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wo_fill: in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
        end
        fill_tile("wo", T1_OPS, 16'hFFFF, 16, 8, 1'b0);
        ctrl("wo", T1_C);
        drain("wo", T1_C, 16'h0002, 3, 1, T1_OPS[31:0]);
        repeat (3) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL wo_extra_beat: out_valid=%b required 0", out_valid);
            end
            tick();
        end
        $display("test_ignore_writeout done");
    endtask

    task automatic test_reset_mid();
        fill_tile("rstmid", T1_OPS, 16'hFFFF, 16, 8, 1'b0);
        ctrl("rstmid", T1_C);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== T1_C[k*CW +: CW]) begin
                bad++;
                $display("FAIL rstmid_beat%0d: valid=%b data=%0d required 1/%0d", k, out_valid, out_data, T1_C[k*CW +: CW]);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || load !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || a_out !== '0 || b_out !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: in_ready=%b load=%b ov=%b ol=%b od=%0d a=%h b=%h busy=%b required all 0", in_ready, load, out_valid, out_last, out_data, a_out, b_out, busy);
        end
        tick();
        rst = 1'b1;
        #1;
        repeat (3) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_idle: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
            end
            tick();
        end
        out_ready = 1'b0;
        fill_tile("rstmid_new", T3_OPS, 16'hFFFF, 16, 8, 1'b0);
        ctrl("rstmid_new", T3_C);
        drain("rstmid_new", T3_C, 16'hFFFF, 16, -1, T3_OPS[31:0]);
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        fill_tile("b2b_1", T1_OPS, 16'hFFFF, 16, 8, 1'b1);
        ctrl("b2b_1", T1_C);
        drain("b2b_1", T1_C, 16'h0005, 4, -1, T1_OPS[31:0]);
        fill_tile("b2b_2", T2_OPS, 16'hFFFF, 16, 8, 1'b1);
        ctrl("b2b_2", T2_C);
        drain("b2b_2", T2_C, 16'hFFFF, 16, -1, T2_OPS[31:0]);
        in_valid = 1'b0;
        $display("test_back_to_back done");
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        write_out = 1'b0;
        c_in      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_bubbles();
        test_ignore_writeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
